// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around an external single-port-write / async-read SRAM,
// with a registered output word giving RAM_DEPTH+1 words of capacity.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] sram_addr_w,
    output logic [DATA_WIDTH-1:0] sram_data_w,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr_r,
    input  logic [DATA_WIDTH-1:0] sram_data_r,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH+1:0] CAP = (ADDR_WIDTH+2)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = (ADDR_WIDTH)'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_used;
    logic [ADDR_WIDTH+1:0] occ;
    logic                  run;
    logic                  accept;
    logic                  load;

    // The pending write (sram_we high) already owns an SRAM slot.
    assign occ = {1'b0, mem_used} + (ADDR_WIDTH+2)'(sram_we);
    assign in_ready = run && !flush && (occ < CAP);
    assign accept = in_valid && in_ready;

    // Only committed words are read, so a read never races its own write.
    assign load = (mem_used != '0) && (!out_valid || out_ready);

    assign sram_addr_r = rd_ptr;
    assign level = mem_used
                 + (ADDR_WIDTH+1)'(sram_we)
                 + (ADDR_WIDTH+1)'(out_valid);
    assign full = (level == FULL_LVL);
    assign empty = (level == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_used    <= '0;
            sram_we     <= 1'b0;
            sram_addr_w <= '0;
            sram_data_w <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else if (flush) begin
            run       <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_used  <= '0;
            sram_we   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            run     <= 1'b1;
            sram_we <= accept;
            if (accept) begin
                sram_addr_w <= wr_ptr;
                sram_data_w <= in_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            // The pending write commits as its sram_we cycle ends.
            mem_used <= mem_used
                      + (ADDR_WIDTH+1)'(sram_we)
                      - (ADDR_WIDTH+1)'(load);
            if (load) begin
                out_data  <= sram_data_r;
                out_valid <= 1'b1;
                rd_ptr    <= rd_ptr + PTR_ONE;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, SHALL be the width of the data words and of the SRAM data ports.
REQ-002 Parameter: ADDR_WIDTH, default 8, SHALL be the width of the SRAM addresses; RAM_DEPTH = 2^ADDR_WIDTH.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 flush  in  1  synchronous clear of all queued data.
REQ-007 in_valid  in  1  producer word valid.
REQ-008 in_ready  out  1  block can accept a word this cycle.
REQ-009 in_data  in  DATA_WIDTH  producer word.
REQ-010 out_valid  out  1  out_data holds the oldest word.
REQ-011 out_ready  in  1  consumer accepts out_data this cycle.
REQ-012 out_data  out  DATA_WIDTH  registered oldest word.
REQ-013 sram_addr_w  out  ADDR_WIDTH  SRAM write address, registered.
REQ-014 sram_data_w  out  DATA_WIDTH  SRAM write data, registered.
REQ-015 sram_we  out  1  SRAM write enable, registered, one-cycle pulse per word.
REQ-016 sram_addr_r  out  ADDR_WIDTH  SRAM read address, equal to the read pointer.
REQ-017 sram_data_r  in  DATA_WIDTH  asynchronous SRAM read data for sram_addr_r.
REQ-018 level  out  ADDR_WIDTH+1  total words held: committed + pending write + output register.
REQ-019 full, empty  out  1 each  level == RAM_DEPTH+1 and level == 0, respectively.

Function
REQ-020 Accept: the block SHALL accept a word at each edge where in_valid && in_ready && !flush.
REQ-021 An accept at edge k SHALL drive sram_we=1, sram_addr_w=wr_ptr and sram_data_w=in_data during cycle k+1, then advance wr_ptr modulo RAM_DEPTH.
REQ-022 sram_we SHALL be 0 in every cycle that does not follow an accept; back-to-back accepts SHALL give a continuous high sram_we with the address incrementing each cycle.
REQ-023 A written word SHALL become committed (readable) at edge k+1, when its sram_we cycle ends.
REQ-024 in_ready SHALL be (mem_used + pending_write) < RAM_DEPTH && !flush, where mem_used counts committed words still in SRAM.
REQ-025 Output register: the block SHALL load out_data <= sram_data_r and advance rd_ptr modulo RAM_DEPTH at any edge where mem_used > 0 and (!out_valid || out_ready).
REQ-026 out_valid SHALL clear at an edge where out_ready && out_valid and no load occurs.
REQ-027 out_data and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-028 Latency: a word accepted at edge k into an otherwise empty block SHALL appear with out_valid=1 after edge k+2.
REQ-029 Throughput: with continuous in_valid and out_ready, the block SHALL sustain one word per cycle in and out.
REQ-030 Reads SHALL only target committed addresses, so the same-address read/write hazard cannot occur.
REQ-031 Simultaneous accept, commit, load and pop in one cycle SHALL update level by (+accept - pop) exactly.
REQ-032 Capacity: RAM_DEPTH words in SRAM plus one in the output register; at level == RAM_DEPTH+1, in_ready SHALL be 0.
REQ-033 Ordering SHALL be strict FIFO across pointer wrap-around.
REQ-034 flush SHALL, at the next edge, zero wr_ptr, rd_ptr, mem_used and level, clear out_valid and the pending write, and force sram_we=0; accepts and pops at that edge SHALL be ignored.

Reset
REQ-035 While rst_n=0, the block SHALL hold: sram_we=0, sram_addr_w=0, sram_data_w=0, sram_addr_r=0, out_valid=0, out_data=0, level=0, empty=1, full=0, in_ready=0.
REQ-036 After rst_n deasserts, in_ready SHALL be 1 from the first clock edge.
REQ-037 Reset asserted mid-operation SHALL abort any pending write; sram_we SHALL fall immediately and asynchronously.

Verification
REQ-038 Single word: accept 0xA5A5 at edge 10 -> sram_we=1 and addr_w=0x00 in cycle 11; out_valid=1 with out_data=0xA5A5 after edge 12; level goes 1,1,1, then 0 after a pop.
REQ-039 Fill: out_ready=0, push 257 words 0x0000..0x0100 -> full=1, in_ready=0, level=257; the 258th in_valid is not accepted.
REQ-040 Drain after fill: out_ready=1 -> outputs 0x0000..0x0100 in order with no gaps; then empty=1.
REQ-041 Wrap: stream 600 incrementing words with random in_valid/out_ready -> in-order output with no loss or duplicates; sram_addr_w wraps 0xFF->0x00.
REQ-042 Backpressure: out_ready held 0 for 5 cycles with out_valid=1 -> out_data stays constant.
REQ-043 Flush/reset: flush or rst_n pulse with level=40 -> level=0, out_valid=0, sram_we=0; the next word pushed writes addr 0x00 and is the next word output.
